// File: rtl/spi_master_tx.sv
// Mode-0 SPI master byte engine: valid/ready byte input, MSB-first serialiser, divided sclk.
// Optional feature macro: SPI_MASTER_TX_LOOPBACK_EN (receive shifter samples mosi_o instead of miso_i).
module spi_master_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       busy_o,
    output logic [1:0] state_o
);

    // Handshake: a byte moves when tx_valid_i && tx_ready_o on a rising clk_i edge.
    // tx_ready_o is high in IDLE and in the single end-of-byte window cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;
    logic [6:0] tx_sh_q, tx_sh_d;
    logic [6:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic       sample_bit;
    logic       div_term;
    logic       eob_window;
    logic       handshake;

`ifdef SPI_MASTER_TX_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = miso_i;
`endif

    assign div_term   = (div_q == DIV_LAST);
    assign eob_window = (state_q == SHIFT) && sclk_q && (cnt_q == 3'd0) && div_term;
    assign tx_ready_o = (state_q == IDLE) || eob_window;
    assign handshake  = tx_valid_i && tx_ready_o;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                if (handshake) begin
                    tx_sh_d = tx_data_i[6:0];
                    mosi_d  = tx_data_i[7];
                    cs_n_d  = 1'b0;
                    cnt_d   = 3'd7;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_term) begin
                    div_d   = 8'd0;
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[5:0], sample_bit};
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_term) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[5:0], sample_bit};
                        if (cnt_q == 3'd0) begin
                            rx_data_d  = {rx_sh_q, sample_bit};
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (cnt_q != 3'd0) begin
                            cnt_d   = cnt_q - 3'd1;
                            mosi_d  = tx_sh_q[6];
                            tx_sh_d = {tx_sh_q[5:0], 1'b0};
                        end else if (tx_valid_i) begin
                            // Back-to-back byte: reload without leaving SHIFT, cs_n stays low.
                            tx_sh_d = tx_data_i[6:0];
                            mosi_d  = tx_data_i[7];
                            cnt_d   = 3'd7;
                        end else begin
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_term) begin
                    div_d   = 8'd0;
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            div_q      <= 8'd0;
            cnt_q      <= 3'd7;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            tx_sh_q    <= 7'd0;
            rx_sh_q    <= 7'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sclk_o     = sclk_q;
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q != IDLE);
    assign state_o    = state_q;

endmodule
